sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter N_CH, default 10, meaning number of sprite channels (2..32).
REQ-002 SHALL have parameter ADDR_W, default 19, meaning sprite ROM read-address width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning overlap-counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 MAX10_CLK1_50  in  1  system clock; all state on the rising edge.
REQ-006 Reset_n  in  1  asynchronous active-low reset.
REQ-007 frame_start  in  1  one-cycle pulse at the start of each frame (vsync).
REQ-008 pixel_valid  in  1  current pixel's channel inputs are valid this cycle.
REQ-009 spr_on  in  N_CH  per-channel "sprite covers pixel" flags.
REQ-010 address  in  N_CH*ADDR_W  flattened per-channel addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 cfg_we  in  1  mask write strobe.
REQ-012 cfg_mask  in  N_CH  channel-enable mask data; 1 = enabled.
REQ-013 out_valid  out  1  outputs below carry a pixel result.
REQ-014 read_address_spr  out  ADDR_W  address of the winning channel.
REQ-015 spr_hit  out  1  at least one enabled channel is active.
REQ-016 spr_id  out  $clog2(N_CH)  index of the winning channel.
REQ-017 overlap  out  1  two or more enabled channels are active.
REQ-018 overlap_cnt_last  out  CNT_W  overlap pixel count of the previous frame.
REQ-019 ch_seen_last  out  N_CH  channels that hit at least once in the previous frame.

Function
REQ-020 The pipeline SHALL have two stages.
  - Stage 1 registers pixel_valid, spr_on AND mask, and address.
  - Stage 2 registers the selection result.
  - Outputs appear exactly 2 cycles after the pixel_valid sample.
REQ-021 Active set = spr_on AND mask; a disabled channel SHALL never win, set overlap, or set ch_seen.
REQ-022 Winner = the active channel i with the largest (i - base) mod N_CH; with base = 0, the highest index wins.
REQ-023 When there is no active channel, the block SHALL drive spr_hit=0, read_address_spr=0, spr_id=0 and overlap=0.
REQ-024 When stage-2 valid is 0, the block SHALL drive out_valid=0 and hold all other pixel outputs at 0.
REQ-025 cfg_we SHALL load mask at the clock edge; pixels sampled in the same cycle use the old mask.
REQ-026 Per-frame counter and seen-register behaviour:
  - Each valid pixel with overlap=1 SHALL increment the internal overlap counter.
  - The counter saturates at 2^CNT_W-1 and SHALL NOT wrap.
  - The winning channel's bit SHALL be OR-ed into the internal seen register.
REQ-027 On frame_start:
  - The internal counter and seen register SHALL be copied to overlap_cnt_last and ch_seen_last.
  - The internal counter and seen register then clear.
REQ-028 When frame_start coincides with a stage-2 valid overlap pixel, that pixel SHALL count toward the new frame (new count = 1), and the latched value SHALL exclude it.
REQ-029 When frame_start and pixel_valid coincide, the pixel SHALL traverse the pipeline normally with no bubble.

Reset
REQ-030 While Reset_n=0, the block SHALL drive every output to 0, clear pipeline valids, set base=0, set mask to all ones, and clear counters and seen registers.
REQ-031 On reset deassertion mid-frame, the block SHALL produce no output until the next pixel_valid and SHALL keep status at 0 until the first frame_start.

Configuration
REQ-032 Macro SPR_ROTATE_PRIO_EN:
  - When defined, each frame_start SHALL increment base, wrapping from N_CH-1 to 0, so overlapping sprites share visibility across frames.
  - When undefined, base SHALL be the constant 0 (fixed highest-index priority) and the rotation logic SHALL be absent.

Verification
REQ-033 The bench SHALL cover: N_CH=10, mask all ones, spr_on=10'b0000100100 with ch2 addr 0x100 and ch5 addr 0x200, pixel_valid at cycle t -> at t+2, out_valid=1, read_address_spr=0x200, spr_id=5, overlap=1.
REQ-034 The bench SHALL cover: cfg_mask=10'b1111011111, then the same pixel -> spr_id=2, read_address_spr=0x100, overlap=0.
REQ-035 The bench SHALL cover: 3 overlap pixels, then frame_start -> overlap_cnt_last=3 and ch_seen_last bit 5 set; a frame with no pixels, then frame_start -> overlap_cnt_last=0 and ch_seen_last=0.
REQ-036 The bench SHALL cover, with CNT_W=4: 20 overlap pixels, then frame_start -> overlap_cnt_last=15.
REQ-037 The bench SHALL cover, with SPR_ROTATE_PRIO_EN defined: ch2 and ch5 active, 4 frame_starts -> base=4, winner=ch2; after 10 frame_starts base returns to 0 and winner=ch5. Undefined: winner is always ch5.
REQ-038 The bench SHALL cover: Reset_n asserted while a pixel is in stage 1 -> out_valid stays 0 and all outputs are 0; after release, the mask reads all ones.

Source files
------------

// File: rtl/sprite_compositor.sv
// Two-stage sprite channel priority selector with per-frame overlap statistics.
// Optional macro SPR_ROTATE_PRIO_EN rotates the priority base once per frame.
module sprite_compositor #(
    parameter int unsigned N_CH   = 10,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       MAX10_CLK1_50,
    input  logic                       Reset_n,
    input  logic                       frame_start,
    input  logic                       pixel_valid,
    input  logic [N_CH-1:0]            spr_on,
    input  logic [N_CH*ADDR_W-1:0]     address,
    input  logic                       cfg_we,
    input  logic [N_CH-1:0]            cfg_mask,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          read_address_spr,
    output logic                       spr_hit,
    output logic [$clog2(N_CH)-1:0]    spr_id,
    output logic                       overlap,
    output logic [CNT_W-1:0]           overlap_cnt_last,
    output logic [N_CH-1:0]            ch_seen_last
);

    localparam int unsigned ID_W = $clog2(N_CH);

    logic [N_CH-1:0]        mask_q;
    logic                   s1_valid;
    logic [N_CH-1:0]        s1_act;
    logic [N_CH*ADDR_W-1:0] s1_addr;
    logic [CNT_W-1:0]       cnt_q;
    logic [N_CH-1:0]        seen_q;

    logic [ID_W-1:0]        sel_id;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_hit;
    logic                   sel_multi;
    int unsigned            rank;
    int unsigned            best_rank;
    logic                   cnt_inc;
    logic [N_CH-1:0]        seen_add;

`ifdef SPR_ROTATE_PRIO_EN
    logic [ID_W-1:0] base;

    always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            base <= '0;
        end else if (frame_start) begin
            base <= (base == ID_W'(N_CH - 1)) ? '0 : base + 1'b1;
        end
    end
`else
    logic [ID_W-1:0] base;
    assign base = '0;
`endif

    // Rank of channel i is (i - base) mod N_CH; highest-ranked active channel wins.
    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_hit   = 1'b0;
        rank      = 0;
        best_rank = 0;
        for (int i = 0; i < N_CH; i++) begin
            rank = 32'(i) + N_CH - 32'(base);
            if (rank >= N_CH) begin
                rank = rank - N_CH;
            end
            if (s1_act[i] && (!sel_hit || rank > best_rank)) begin
                sel_hit   = 1'b1;
                best_rank = rank;
                sel_id    = ID_W'(i);
                sel_addr  = s1_addr[i*ADDR_W +: ADDR_W];
            end
        end
        sel_multi = |(s1_act & (s1_act - {{(N_CH-1){1'b0}}, 1'b1}));
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            mask_q   <= '1;
            s1_valid <= 1'b0;
            s1_act   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= pixel_valid;
            s1_act   <= spr_on & mask_q;
            s1_addr  <= address;
            if (cfg_we) begin
                mask_q <= cfg_mask;
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid        <= 1'b0;
            read_address_spr <= '0;
            spr_hit          <= 1'b0;
            spr_id           <= '0;
            overlap          <= 1'b0;
        end else if (s1_valid) begin
            out_valid        <= 1'b1;
            read_address_spr <= sel_addr;
            spr_hit          <= sel_hit;
            spr_id           <= sel_id;
            overlap          <= sel_multi;
        end else begin
            out_valid        <= 1'b0;
            read_address_spr <= '0;
            spr_hit          <= 1'b0;
            spr_id           <= '0;
            overlap          <= 1'b0;
        end
    end

    assign cnt_inc  = out_valid & overlap;
    assign seen_add = (out_valid && spr_hit) ? ({{(N_CH-1){1'b0}}, 1'b1} << spr_id) : '0;

    // A result visible on the frame_start cycle belongs to the new frame.
    always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q            <= '0;
            seen_q           <= '0;
            overlap_cnt_last <= '0;
            ch_seen_last     <= '0;
        end else if (frame_start) begin
            overlap_cnt_last <= cnt_q;
            ch_seen_last     <= seen_q;
            cnt_q            <= {{(CNT_W-1){1'b0}}, cnt_inc};
            seen_q           <= seen_add;
        end else begin
            if (cnt_inc && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            seen_q <= seen_q | seen_add;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized and directed bench for sprite_compositor against a cycle-level reference model.
module tb_sprite_compositor;

    localparam int N  = 10;
    localparam int AW = 19;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              pixel_valid = 1'b0;
    logic [N-1:0]      spr_on = '0;
    logic [N*AW-1:0]   address = '0;
    logic              cfg_we = 1'b0;
    logic [N-1:0]      cfg_mask = '0;

    logic              out_valid, spr_hit, overlap;
    logic [AW-1:0]     read_address_spr;
    logic [IW-1:0]     spr_id;
    logic [15:0]       overlap_cnt_last;
    logic [N-1:0]      ch_seen_last;

    logic              out_valid4, spr_hit4, overlap4;
    logic [AW-1:0]     read_address_spr4;
    logic [IW-1:0]     spr_id4;
    logic [3:0]        overlap_cnt_last4;
    logic [N-1:0]      ch_seen_last4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic          m_s1_v;
    logic [N-1:0]  m_s1_act;
    logic [N*AW-1:0] m_s1_addr;
    logic          m_ov, m_ohit, m_oovl;
    logic [AW-1:0] m_oaddr;
    int            m_oid;
    logic [N-1:0]  m_mask, m_seen, m_seen_last;
    int            m_base, m_cnt, m_cnt4, m_cnt_last, m_cnt4_last;

    sprite_compositor #(.N_CH(N), .ADDR_W(AW), .CNT_W(16)) dut (
        .MAX10_CLK1_50(clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .spr_on(spr_on), .address(address),
        .cfg_we(cfg_we), .cfg_mask(cfg_mask), .out_valid(out_valid),
        .read_address_spr(read_address_spr), .spr_hit(spr_hit), .spr_id(spr_id),
        .overlap(overlap), .overlap_cnt_last(overlap_cnt_last), .ch_seen_last(ch_seen_last)
    );

    sprite_compositor #(.N_CH(N), .ADDR_W(AW), .CNT_W(4)) dut4 (
        .MAX10_CLK1_50(clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .spr_on(spr_on), .address(address),
        .cfg_we(cfg_we), .cfg_mask(cfg_mask), .out_valid(out_valid4),
        .read_address_spr(read_address_spr4), .spr_hit(spr_hit4), .spr_id(spr_id4),
        .overlap(overlap4), .overlap_cnt_last(overlap_cnt_last4),
        .ch_seen_last(ch_seen_last4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1_v = 0; m_s1_act = '0; m_s1_addr = '0;
        m_ov = 0; m_ohit = 0; m_oovl = 0; m_oaddr = '0; m_oid = 0;
        m_mask = '1; m_seen = '0; m_seen_last = '0;
        m_base = 0; m_cnt = 0; m_cnt4 = 0; m_cnt_last = 0; m_cnt4_last = 0;
    endtask

    // Winner = active channel with the largest (i - base) mod N.
    task automatic predict(input logic v, input logic [N-1:0] act, input logic [N*AW-1:0] addr,
                           input int base, output logic o_v, output logic [AW-1:0] o_addr,
                           output logic o_hit, output int o_id, output logic o_ovl);
        int best;
        int nact;
        best = -1; nact = 0;
        o_v = 0; o_addr = '0; o_hit = 0; o_id = 0; o_ovl = 0;
        if (v) begin
            o_v = 1;
            for (int i = 0; i < N; i++) begin
                if (act[i]) begin
                    nact++;
                    if ((i - base + N) % N > best) begin
                        best = (i - base + N) % N;
                        o_id = i;
                    end
                end
            end
            if (nact > 0) begin
                o_hit = 1;
                o_addr = addr[o_id*AW +: AW];
            end
            o_ovl = (nact >= 2);
        end
    endtask

    task automatic model_update();
        int inc;
        logic [N-1:0] sbit;
        inc = (m_ov && m_oovl) ? 1 : 0;
        sbit = (m_ov && m_ohit) ? N'(1 << m_oid) : '0;
        if (frame_start) begin
            m_cnt_last = m_cnt; m_cnt4_last = m_cnt4; m_seen_last = m_seen;
            m_cnt = inc; m_cnt4 = inc; m_seen = sbit;
        end else begin
            m_cnt  = (m_cnt + inc > 65535) ? 65535 : m_cnt + inc;
            m_cnt4 = (m_cnt4 + inc > 15) ? 15 : m_cnt4 + inc;
            m_seen = m_seen | sbit;
        end
        predict(m_s1_v, m_s1_act, m_s1_addr, m_base, m_ov, m_oaddr, m_ohit, m_oid, m_oovl);
        m_s1_v = pixel_valid;
        m_s1_act = spr_on & m_mask;
        m_s1_addr = address;
        if (cfg_we) m_mask = cfg_mask;
`ifdef SPR_ROTATE_PRIO_EN
        if (frame_start) m_base = (m_base + 1) % N;
`endif
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("read_address_spr", 64'(read_address_spr), 64'(m_oaddr));
        check("spr_hit", 64'(spr_hit), 64'(m_ohit));
        check("spr_id", 64'(spr_id), 64'(m_oid));
        check("overlap", 64'(overlap), 64'(m_oovl));
        check("overlap_cnt_last", 64'(overlap_cnt_last), 64'(m_cnt_last));
        check("ch_seen_last", 64'(ch_seen_last), 64'(m_seen_last));
        check("overlap_cnt_last_w4", 64'(overlap_cnt_last4), 64'(m_cnt4_last));
    endtask

    task automatic step();
        if (!Reset_n) model_reset();
        else model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        pixel_valid = 0; spr_on = '0; frame_start = 0; cfg_we = 0;
    endtask

    task automatic set_pixel(input logic [N-1:0] on);
        for (int i = 0; i < N; i++) address[i*AW +: AW] = AW'($urandom);
        address[2*AW +: AW] = AW'(32'h100);
        address[5*AW +: AW] = AW'(32'h200);
        spr_on = on;
        pixel_valid = 1;
    endtask

    task automatic pulse_fs();
        frame_start = 1;
        step();
        frame_start = 0;
    endtask

    task automatic do_reset();
        idle();
        Reset_n = 0;
        model_reset();
        #1;
        compare_all();
        step();
        step();
        Reset_n = 1;
        step();
    endtask

    // One 2/5 pixel, then one idle cycle so its result is visible.
    task automatic pixel_25();
        set_pixel(10'b0000100100);
        step();
        idle();
        step();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Two overlapping channels, highest index wins by default
        pixel_25();
        check("r33_valid", 64'(out_valid), 64'd1);
        check("r33_addr", 64'(read_address_spr), 64'h200);
        check("r33_id", 64'(spr_id), 64'd5);
        check("r33_ovl", 64'(overlap), 64'd1);

        // Masked-off channel 5 must lose
        cfg_we = 1; cfg_mask = 10'b1111011111;
        step();
        cfg_we = 0;
        pixel_25();
        check("r34_id", 64'(spr_id), 64'd2);
        check("r34_addr", 64'(read_address_spr), 64'h100);
        check("r34_ovl", 64'(overlap), 64'd0);

        // Per-frame statistics
        do_reset();
        pulse_fs();
        for (int k = 0; k < 3; k++) begin
            set_pixel(10'b0000100100);
            step();
        end
        idle();
        repeat (3) step();
        pulse_fs();
        check("r35_cnt3", 64'(overlap_cnt_last), 64'd3);
        check("r35_seen5", 64'(ch_seen_last[5]), 64'd1);
        repeat (2) step();
        pulse_fs();
        check("r35_cnt0", 64'(overlap_cnt_last), 64'd0);
        check("r35_seen0", 64'(ch_seen_last), 64'd0);

        // Saturation of the narrow counter
        for (int k = 0; k < 20; k++) begin
            set_pixel(10'b0000100100);
            step();
        end
        idle();
        repeat (3) step();
        pulse_fs();
        check("r36_sat15", 64'(overlap_cnt_last4), 64'd15);
        check("r36_cnt20", 64'(overlap_cnt_last), 64'd20);

        // Priority rotation
        do_reset();
        repeat (4) pulse_fs();
        pixel_25();
`ifdef SPR_ROTATE_PRIO_EN
        check("r37_base4_id", 64'(spr_id), 64'd2);
`else
        check("r37_base4_id", 64'(spr_id), 64'd5);
`endif
        repeat (6) pulse_fs();
        pixel_25();
        check("r37_base0_id", 64'(spr_id), 64'd5);

        // Reset while a pixel sits in stage 1
        set_pixel(10'b0000100100);
        step();
        idle();
        Reset_n = 0;
        model_reset();
        #1;
        check("r38_valid_in_rst", 64'(out_valid), 64'd0);
        check("r38_outs_in_rst", 64'({read_address_spr, spr_hit, spr_id, overlap}), 64'd0);
        step();
        step();
        Reset_n = 1;
        step();
        check("r38_valid_after", 64'(out_valid), 64'd0);
        pixel_25();
        check("r38_mask_ones_id", 64'(spr_id), 64'd5);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            pixel_valid = ($urandom_range(0, 3) != 0);
            spr_on = N'($urandom & $urandom & $urandom);
            for (int i = 0; i < N; i++) address[i*AW +: AW] = AW'($urandom);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_mask = N'($urandom | $urandom);
            frame_start = ($urandom_range(0, 24) == 0);
            step();
        end
        idle();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
